ddr_read_arbiter: RTL and testbench
===================================

Name: ddr_read_arbiter

Overview:
Shares one DDR read port between NUM_REQ burst-fetch clients in the MPEG/FMV video path, for example the Y, U and V plane fetchers of the frame player and the decoder reference-frame reader. Each client posts a byte address and a burst length. The arbiter grants clients round-robin, issues the read with the core DDR base prepended, holds acquire for the whole burst, and steers the returning beats back to the granted client. It runs on the DDR clock domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
BURST_W, 8, width of burst length fields
TIMEOUT_CYCLES, 1024, watchdog limit per burst (used only with the optional feature)

Ports:
clk  in  1  DDR-domain clock
reset_n  in  1  synchronous, active-low reset
req_valid  in  NUM_REQ  client i requests a burst; held until req_ready[i]
req_addr  in  NUM_REQ*29  byte address per client, packed with client i at [29*i +: 29]
req_burstcnt  in  NUM_REQ*BURST_W  burst length in 64-bit beats per client
req_ready  out  NUM_REQ  one-cycle pulse: request accepted
rdata_valid  out  NUM_REQ  beat for client i is on rdata
rdata  out  64  read data, passthrough of ddr_rdata
ddr_addr  out  29  DDR word address
ddr_burstcnt  out  BURST_W  burst length to DDR
ddr_read  out  1  read strobe
ddr_acquire  out  1  bus ownership for the burst
ddr_busy  in  1  DDR not ready to take a command
ddr_rdata  in  64  returning data
ddr_rdata_ready  in  1  beat valid
busy  out  1  burst in flight (state other than IDLE)
error  out  1  sticky watchdog abort flag (always 0 without the optional feature)

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE; ddr_read, ddr_acquire, req_ready, error all 0.
  - rr_ptr=0; beat counter=0.
  - rdata_valid is forced 0 combinationally while reset_n=0.
  - Reset mid-burst abandons the burst. Beats still in flight are not routed.
- States: IDLE, ISSUE, DATA.
- IDLE:
  - Select the first asserted req_valid, searching from rr_ptr upward with wrap.
  - Winner g: req_ready[g]=1 for one cycle, then latch addr and burstcnt. Set rr_ptr=(g+1) mod NUM_REQ.
  - If the latched burstcnt is 0: complete immediately. No DDR command is issued, state stays IDLE, and the next grant is possible 1 cycle later.
  - Otherwise: ddr_addr={4'b0011, req_addr[27:3]}, ddr_burstcnt=burstcnt, ddr_read=1, ddr_acquire=1, remaining=burstcnt, state goes to ISSUE.
  - Latency from req_valid to ddr_read is 1 cycle when the port is free.
- ISSUE:
  - ddr_read is held at 1 until a cycle where ddr_busy=0. ddr_read deasserts on the following edge, and state goes to DATA.
  - Beats arriving in ISSUE are counted and routed.
- DATA:
  - Each ddr_rdata_ready decrements remaining.
  - On the beat that makes remaining 0: state goes to IDLE and ddr_acquire goes to 0 on the same edge.
  - A new grant is possible on the next cycle.
- Routing: rdata_valid[i] = ddr_rdata_ready && state!=IDLE && grant==i. This is combinational, with zero latency. rdata=ddr_rdata.
- Beats arriving in IDLE are dropped. No client sees them.
- The low 3 bits of req_addr are ignored. Clients supply 8-byte-aligned addresses.
- req_valid deasserting before req_ready is a client protocol violation. The arbiter does not check for it.

Optional Feature:
- Macro: DDR_ARB_TIMEOUT_EN.
- Enabled:
  - A watchdog counts cycles spent in ISSUE/DATA and clears on each grant.
  - When it reaches TIMEOUT_CYCLES: state goes to IDLE, ddr_read=0, ddr_acquire=0, and error is set sticky until reset. Arbitration resumes.
- Disabled:
  - No counter is built; error is tied 0.
  - A missing beat stalls the arbiter indefinitely.

Decomposition:
- Package ddr_arb_pkg holds:
  - DDR_CORE_BASE=4'b0011;
  - the arb_state_e enum {IDLE, ISSUE, DATA};
  - DDR_DATA_W=64;
  - DDR_ADDR_W=29.
- One sub-module, rr_priority_picker: combinational round-robin first-one search returning a grant index and a found flag. It is parameterised by NUM_REQ.

Test Plan:
- Single client: req 2, addr 0x0015900, burst 25, ddr_busy=0 → req_ready[2] pulses; next cycle ddr_addr=0x06002B20, ddr_burstcnt=25; exactly 25 rdata_valid[2] pulses; acquire drops on beat 25.
- Contention: all 4 clients request continuously, burst 2 → grant order 0,1,2,3,0,1; no overlapping acquire; each client sees exactly 2 beats per grant.
- Backpressure: ddr_busy held 1 for 7 cycles after issue → ddr_read stays 1 for 8 cycles, ddr_addr stable throughout, then DATA.
- Zero burst: client 1, burst 0 → req_ready[1] pulses, no ddr_read, busy stays 0, client 3 is granted on the following cycle.
- Reset mid-burst: reset_n=0 after beat 10 of 50 → next edge state IDLE, acquire=0; rdata_valid stays 0 for the remaining 40 beats.
- With DDR_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, a burst of 4 gets only 2 beats → at cycle 16 error=1, acquire=0, and the pending client 0 is then granted.

Source files
------------

// File: rtl/ddr_read_arbiter_pkg.sv
// Shared types and constants for the DDR read-port arbiter.
// Latency: n/a (declarations only).  Backpressure: n/a.
package ddr_arb_pkg;

    localparam int         DDR_DATA_W    = 64;
    localparam int         DDR_ADDR_W    = 29;
    localparam logic [3:0] DDR_CORE_BASE = 4'b0011;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DATA
    } arb_state_e;

endpackage

// File: rtl/ddr_read_arbiter_if.sv
// Client request/return bundle plus the shared DDR read-port signals.
// Latency: n/a (wiring only).  Backpressure: ddr_busy stalls the read command.
interface ddr_read_arbiter_if
    import ddr_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int BURST_W = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DDR_ADDR_W-1:0] req_addr;
    logic [NUM_REQ*BURST_W-1:0]    req_burstcnt;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rdata_valid;
    logic [DDR_DATA_W-1:0]         rdata;
    logic [DDR_ADDR_W-1:0]         ddr_addr;
    logic [BURST_W-1:0]            ddr_burstcnt;
    logic                          ddr_read;
    logic                          ddr_acquire;
    logic                          ddr_busy;
    logic [DDR_DATA_W-1:0]         ddr_rdata;
    logic                          ddr_rdata_ready;

    modport master (
        input  req_valid, req_addr, req_burstcnt, ddr_busy, ddr_rdata, ddr_rdata_ready,
        output req_ready, rdata_valid, rdata, ddr_addr, ddr_burstcnt, ddr_read, ddr_acquire
    );

    modport slave (
        output req_valid, req_addr, req_burstcnt, ddr_busy, ddr_rdata, ddr_rdata_ready,
        input  req_ready, rdata_valid, rdata, ddr_addr, ddr_burstcnt, ddr_read, ddr_acquire
    );

endinterface

// File: rtl/ddr_read_arbiter_picker.sv
// Round-robin first-one search starting at ptr, wrapping past NUM_REQ-1.
// Latency: combinational.  Backpressure: none.
module rr_priority_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       found
);
    localparam int PTR_W = $clog2(NUM_REQ);

    function automatic logic [PTR_W-1:0] slot(input logic [PTR_W-1:0] base, input int ofs);
        int j;
        j = int'(base) + ofs;
        if (j >= NUM_REQ) j = j - NUM_REQ;
        return j[PTR_W-1:0];
    endfunction

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[slot(ptr, i)]) begin
                idx   = slot(ptr, i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr_read_arbiter.sv
// Round-robin arbiter sharing one DDR read port; optional watchdog via DDR_ARB_TIMEOUT_EN.
// Latency: req_valid to ddr_read 1 cycle when idle; return beats routed combinationally.
// Backpressure: ddr_read held while ddr_busy; clients wait on req_ready until port is free.
module ddr_read_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int BURST_W        = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset_n,
    ddr_read_arbiter_if.master  bus,
    output logic                busy,
    output logic                error
);
    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_e              state_q, state_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]        grant_q, grant_d;
    logic [DDR_ADDR_W-1:0]   ddr_addr_q, ddr_addr_d;
    logic [BURST_W-1:0]      burst_q, burst_d;
    logic [BURST_W-1:0]      rem_q, rem_d;
    logic                    read_q, read_d;
    logic                    acq_q, acq_d;
    logic [NUM_REQ-1:0]      ready_q, ready_d;

    logic [PTR_W-1:0]        pick_idx;
    logic                    pick_found;
    logic [DDR_ADDR_W-5:0]   sel_word;
    logic [BURST_W-1:0]      sel_burst;
    logic                    beat;

`ifdef DDR_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
`endif

    // A client whose accept pulse is still visible must not be picked again.
    rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req   (bus.req_valid & ~ready_q),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign sel_word  = bus.req_addr[int'(pick_idx)*DDR_ADDR_W + 3 +: DDR_ADDR_W-4];
    assign sel_burst = bus.req_burstcnt[int'(pick_idx)*BURST_W +: BURST_W];
    assign beat      = bus.ddr_rdata_ready;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        ddr_addr_d = ddr_addr_q;
        burst_d    = burst_q;
        rem_d      = rem_q;
        read_d     = read_q;
        acq_d      = acq_q;
        ready_d    = '0;
`ifdef DDR_ARB_TIMEOUT_EN
        wd_d       = wd_q;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    ready_d[pick_idx] = 1'b1;
                    grant_d           = pick_idx;
                    rr_ptr_d          = (int'(pick_idx) == NUM_REQ-1) ? '0 : pick_idx + 1'b1;
                    burst_d           = sel_burst;
`ifdef DDR_ARB_TIMEOUT_EN
                    wd_d              = '0;
`endif
                    // Zero-length bursts complete on acceptance with no DDR command.
                    if (sel_burst != '0) begin
                        ddr_addr_d = {DDR_CORE_BASE, sel_word};
                        rem_d      = sel_burst;
                        read_d     = 1'b1;
                        acq_d      = 1'b1;
                        state_d    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (beat && rem_q != '0) rem_d = rem_q - 1'b1;
                if (!bus.ddr_busy) begin
                    read_d  = 1'b0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (rem_q == '0 || (beat && rem_q == BURST_W'(1))) begin
                    rem_d   = '0;
                    acq_d   = 1'b0;
                    state_d = IDLE;
                end else if (beat) begin
                    rem_d = rem_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef DDR_ARB_TIMEOUT_EN
        if (state_q != IDLE) begin
            if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = IDLE;
                read_d  = 1'b0;
                acq_d   = 1'b0;
                err_d   = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            ddr_addr_q <= '0;
            burst_q    <= '0;
            rem_q      <= '0;
            read_q     <= 1'b0;
            acq_q      <= 1'b0;
            ready_q    <= '0;
`ifdef DDR_ARB_TIMEOUT_EN
            wd_q       <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            ddr_addr_q <= ddr_addr_d;
            burst_q    <= burst_d;
            rem_q      <= rem_d;
            read_q     <= read_d;
            acq_q      <= acq_d;
            ready_q    <= ready_d;
`ifdef DDR_ARB_TIMEOUT_EN
            wd_q       <= wd_d;
            err_q      <= err_d;
`endif
        end
    end

    // Beats seen outside a burst, or during reset, belong to nobody.
    always_comb begin
        bus.rdata_valid = '0;
        if (reset_n && beat && state_q != IDLE) bus.rdata_valid[grant_q] = 1'b1;
    end

    assign bus.rdata        = bus.ddr_rdata;
    assign bus.req_ready    = ready_q;
    assign bus.ddr_addr     = ddr_addr_q;
    assign bus.ddr_burstcnt = burst_q;
    assign bus.ddr_read     = read_q;
    assign bus.ddr_acquire  = acq_q;
    assign busy             = (state_q != IDLE);
`ifdef DDR_ARB_TIMEOUT_EN
    assign error            = err_q;
`else
    assign error            = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_read_arbiter.sv
// Directed bench for ddr_read_arbiter: vector table of single bursts plus
// hand-written contention, zero-burst, reset and watchdog sequences.
module tb_ddr_read_arbiter;
    import ddr_arb_pkg::*;

    localparam int NR = 4;
    localparam int BW = 8;
`ifdef DDR_ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic busy;
    logic error;

    ddr_read_arbiter_if #(.NUM_REQ(NR), .BURST_W(BW)) bus ();

    ddr_read_arbiter #(.NUM_REQ(NR), .BURST_W(BW), .TIMEOUT_CYCLES(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy),
        .error   (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          client;
        logic [28:0] addr;
        int          burst;
        int          busy_cyc;
        logic [28:0] exp_addr;
    } vec_t;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int c, input logic [28:0] a, input int b);
        logic [7:0] b8;
        b8 = b[7:0];
        bus.req_addr[c*29 +: 29]    = a;
        bus.req_burstcnt[c*BW +: BW] = b8;
    endtask

    task automatic do_reset();
        reset_n             = 1'b0;
        bus.req_valid       = '0;
        bus.ddr_busy        = 1'b0;
        bus.ddr_rdata_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_read", bus.ddr_read, 0);
        chk("rst_acquire", bus.ddr_acquire, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_error", error, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdata_valid", bus.rdata_valid, 0);
        bus.ddr_rdata_ready = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Deliver n beats, counting those routed only to client c with correct data.
    task automatic beats(input int c, input int n, output int got);
        logic [63:0] d;
        logic [3:0]  oh;
        oh  = 4'b0001 << c;
        got = 0;
        for (int b = 0; b < n; b++) begin
            d = 64'hA5A5_0000_0000_0000 | 64'(b + 256 * c);
            bus.ddr_rdata_ready = 1'b1;
            bus.ddr_rdata       = d;
            #1;
            if (bus.rdata_valid == oh && bus.rdata == d) got++;
            @(negedge clk);
        end
        bus.ddr_rdata_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [3:0] oh;
        int busy_left, rd_cycles, got;
        logic addr_ok;
        oh = 4'b0001 << v.client;
        set_req(v.client, v.addr, v.burst);
        bus.req_valid = oh;
        @(negedge clk);
        chk("vec_req_ready", bus.req_ready, oh);
        chk("vec_read", bus.ddr_read, 1);
        chk("vec_addr", bus.ddr_addr, v.exp_addr);
        chk("vec_burstcnt", bus.ddr_burstcnt, v.burst);
        chk("vec_acquire", bus.ddr_acquire, 1);
        bus.req_valid = '0;
        busy_left = v.busy_cyc;
        rd_cycles = 0;
        addr_ok   = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (!bus.ddr_read) break;
            rd_cycles++;
            if (bus.ddr_addr !== v.exp_addr) addr_ok = 1'b0;
            bus.ddr_busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            @(negedge clk);
        end
        bus.ddr_busy = 1'b0;
        chk("vec_read_cycles", rd_cycles, v.busy_cyc + 1);
        chk("vec_addr_stable", addr_ok, 1);
        beats(v.client, v.burst - 1, got);
        chk("vec_acq_before_last", bus.ddr_acquire, 1);
        beats(v.client, 1, rd_cycles);
        chk("vec_beats", got + rd_cycles, v.burst);
        chk("vec_acq_after_last", bus.ddr_acquire, 0);
        chk("vec_busy_after_last", busy, 0);
    endtask

    vec_t vecs[4];
    int   order[6];
    int   got;
    bit   ok;

    initial begin
        bus.req_valid       = '0;
        bus.req_addr        = '0;
        bus.req_burstcnt    = '0;
        bus.ddr_busy        = 1'b0;
        bus.ddr_rdata       = '0;
        bus.ddr_rdata_ready = 1'b0;

        vecs[0] = '{2, 29'h0015900,  25, 0, 29'h06002B20};
        vecs[1] = '{0, 29'h0FFFFFF8,  3, 7, 29'h07FFFFFF};
        vecs[2] = '{3, 29'h10000107,  1, 2, 29'h06000020};
        vecs[3] = '{1, 29'h0ABCDE0,   4, 0, 29'h061579BC};
        order   = '{0, 1, 2, 3, 0, 1};

        do_reset();

`ifdef DDR_ARB_TIMEOUT_EN
        // Watchdog: burst of 4 receives only 2 beats.
        set_req(2, 29'h800, 4);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        chk("wd_grant", bus.req_ready, 4'b0100);
        bus.req_valid = '0;
        got = 0;
        for (int k = 0; k < 100; k++) begin
            if (!busy) break;
            bus.ddr_rdata_ready = (got == 1 || got == 2);
            if (got == 3) begin
                set_req(0, 29'h40, 1);
                bus.req_valid = 4'b0001;
            end
            @(negedge clk);
            got++;
        end
        bus.ddr_rdata_ready = 1'b0;
        chk("wd_cycles", got, 16);
        chk("wd_error", error, 1);
        chk("wd_acquire", bus.ddr_acquire, 0);
        chk("wd_read", bus.ddr_read, 0);
        @(negedge clk);
        chk("wd_next_grant", bus.req_ready, 4'b0001);
        bus.req_valid = '0;
`else
        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Contention: all clients request continuously, burst 2.
        do_reset();
        for (int c = 0; c < NR; c++) set_req(c, 29'(c * 64), 2);
        bus.req_valid = 4'b1111;
        for (int g = 0; g < 6; g++) begin
            ok = 1'b0;
            for (int k = 0; k < 20; k++) begin
                if (bus.req_ready != 0) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            chk("cont_grant_seen", ok, 1);
            chk("cont_grant_order", bus.req_ready, 4'b0001 << order[g]);
            chk("cont_acquire", bus.ddr_acquire, 1);
            @(negedge clk);
            chk("cont_read_done", bus.ddr_read, 0);
            beats(order[g], 2, got);
            chk("cont_beats", got, 2);
            chk("cont_acq_released", bus.ddr_acquire, 0);
        end
        bus.req_valid = '0;
        @(negedge clk);

        // Zero-length burst on client 1, client 3 queued behind it.
        do_reset();
        set_req(1, 29'h100, 0);
        set_req(3, 29'h40, 2);
        bus.req_valid = 4'b1010;
        @(negedge clk);
        chk("zero_ready", bus.req_ready, 4'b0010);
        chk("zero_no_read", bus.ddr_read, 0);
        chk("zero_busy", busy, 0);
        chk("zero_no_acquire", bus.ddr_acquire, 0);
        bus.req_valid[1] = 1'b0;
        @(negedge clk);
        chk("zero_next_grant", bus.req_ready, 4'b1000);
        chk("zero_next_read", bus.ddr_read, 1);
        chk("zero_next_addr", bus.ddr_addr, 29'h06000008);
        bus.req_valid[3] = 1'b0;
        @(negedge clk);
        beats(3, 2, got);
        chk("zero_next_beats", got, 2);
        bus.ddr_rdata_ready = 1'b1;
        #1;
        chk("idle_beat_drop", bus.rdata_valid, 0);
        bus.ddr_rdata_ready = 1'b0;
        @(negedge clk);

        // Reset after beat 10 of a 50-beat burst.
        set_req(0, 29'h2000, 50);
        bus.req_valid = 4'b0001;
        @(negedge clk);
        chk("rstmid_grant", bus.req_ready, 4'b0001);
        bus.req_valid = '0;
        @(negedge clk);
        beats(0, 10, got);
        chk("rstmid_first_beats", got, 10);
        reset_n = 1'b0;
        got = 0;
        for (int b = 0; b < 40; b++) begin
            bus.ddr_rdata_ready = 1'b1;
            bus.ddr_rdata       = 64'(b);
            #1;
            if (bus.rdata_valid != 0) got++;
            if (b == 1) begin
                chk("rstmid_acquire", bus.ddr_acquire, 0);
                chk("rstmid_busy", busy, 0);
            end
            if (b == 2) reset_n = 1'b1;
            @(negedge clk);
        end
        bus.ddr_rdata_ready = 1'b0;
        chk("rstmid_routed_after", got, 0);
        chk("error_tied_low", error, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
